// File: rtl/sap2_prog_loader.sv
// ----------------------------------------------------------------------------
// sap2_prog_loader
//   Hardware program loader for the SAP-2 mini CPU. Accepts a framed byte
//   stream from a host (COUNT, then COUNT words sent as HI/LO byte pairs) and
//   writes each word into the CPU through its programming port (prog, a, d)
//   at consecutive addresses from 00H. Once the last word is written, prog is
//   released, cpu_clr is pulsed, and done is pulsed for one cycle.
//
//   Optional feature macro: SAP2_LOADER_CHECKSUM_EN
//     When defined, one extra check byte follows the last word. The 8-bit sum
//     of COUNT, every HI/LO byte and the check byte must be 00H. On a
//     mismatch err is set, the CPU clear is skipped, and done still pulses.
//     When undefined, there is no check byte and err is tied to 0.
//
// Parameters
//   HOLD        cycles prog stays high per word       (1..15)
//   CLR_CYCLES  cycles cpu_clr stays high after load  (1..15)
//
// Ports
//   clk       in   1   system clock, rising edge
//   clr_n     in   1   synchronous active-low reset
//   in_data   in   8   host byte
//   in_valid  in   1   host byte valid
//   in_ready  out  1   loader can accept in_data (combinational from state)
//   prog      out  1   CPU program-mode strobe
//   a         out  8   CPU program address
//   d         out  12  CPU program word
//   cpu_clr   out  1   CPU clear, active high
//   busy      out  1   frame in progress
//   done      out  1   one-cycle pulse at frame completion
//   err       out  1   checksum failure, sticky until the next COUNT byte
// ----------------------------------------------------------------------------
module sap2_prog_loader #(
  parameter int HOLD       = 2,
  parameter int CLR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        prog,
  output logic [7:0]  a,
  output logic [11:0] d,
  output logic        cpu_clr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WRITE, S_CHK, S_CLR, S_DONE
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
  localparam logic [3:0] CLR_LAST  = 4'(CLR_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_count;
  logic [7:0]  r_wptr;
  logic [7:0]  r_a;
  logic [11:0] r_d;
  logic [3:0]  r_nib;
  logic [3:0]  r_cnt;
  logic        w_xfer;
  logic        w_last;
  logic        w_holdEnd;
  logic        w_clrEnd;

  assign w_xfer    = in_valid & in_ready;
  // COUNT=00H wraps to FFH here, so a 256-word frame ends at wptr=FFH.
  assign w_last    = (r_wptr == (r_count - 8'd1));
  assign w_holdEnd = (r_cnt == HOLD_LAST);
  assign w_clrEnd  = (r_cnt == CLR_LAST);

`ifdef SAP2_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_err;
  logic [7:0] w_sumNext;
  logic       w_chkOk;

  assign w_sumNext = r_sum + in_data;
  assign w_chkOk   = (w_sumNext == 8'h00);
  assign err       = r_err;

  // Running checksum and sticky error flag; both restart on a COUNT byte.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_sum <= 8'h00;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:     if (w_xfer) begin r_sum <= in_data; r_err <= 1'b0; end
        S_HI, S_LO: if (w_xfer) r_sum <= w_sumNext;
        S_CHK:      if (w_xfer && !w_chkOk) r_err <= 1'b1;
        default:    ;
      endcase
    end
  end
`else
  assign err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!clr_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_next = S_HI;
      S_HI:    if (w_xfer) w_next = S_LO;
      S_LO:    if (w_xfer) w_next = S_WRITE;
      S_WRITE: begin
        if (w_holdEnd) begin
`ifdef SAP2_LOADER_CHECKSUM_EN
          w_next = w_last ? S_CHK : S_HI;
`else
          w_next = w_last ? S_CLR : S_HI;
`endif
        end
      end
`ifdef SAP2_LOADER_CHECKSUM_EN
      S_CHK:   if (w_xfer) w_next = w_chkOk ? S_CLR : S_DONE;
`endif
      S_CLR:   if (w_clrEnd) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; prog and cpu_clr come from distinct states
  // so they can never be high together, and reset drops prog immediately.
  always_comb begin
    in_ready = 1'b0;
    prog     = 1'b0;
    cpu_clr  = 1'b0;
    done     = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE, S_HI, S_LO: in_ready = 1'b1;
`ifdef SAP2_LOADER_CHECKSUM_EN
      S_CHK:   in_ready = 1'b1;
`endif
      S_WRITE: prog     = 1'b1;
      S_CLR:   cpu_clr  = 1'b1;
      S_DONE:  done     = 1'b1;
      default: ;
    endcase
  end

  // Datapath: the cycle counter restarts on every state change and times
  // both the prog window and the clear pulse. a/d only change when a LO
  // byte is accepted, so they are stable for the whole prog window.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_count <= 8'h00;
      r_wptr  <= 8'h00;
      r_a     <= 8'h00;
      r_d     <= 12'h000;
      r_nib   <= 4'h0;
      r_cnt   <= 4'h0;
    end else begin
      if (w_next != r_state) r_cnt <= 4'h0;
      else                   r_cnt <= r_cnt + 4'h1;
      case (r_state)
        S_IDLE: if (w_xfer) begin r_count <= in_data; r_wptr <= 8'h00; end
        S_HI:   if (w_xfer) r_nib <= in_data[3:0];
        S_LO:   if (w_xfer) begin r_a <= r_wptr; r_d <= {r_nib, in_data}; end
        S_WRITE: if (w_holdEnd) r_wptr <= r_wptr + 8'd1;
        default: ;
      endcase
    end
  end

  assign a = r_a;
  assign d = r_d;

endmodule

// File: tb/tb_sap2_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_sap2_prog_loader
//   Directed self-checking bench for sap2_prog_loader. A negedge monitor
//   records every prog window (address, word, length), clear-pulse cycles,
//   done pulses and protocol anomalies; each test task then compares what
//   was recorded against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_sap2_prog_loader;

  localparam int HOLD = 2;
  localparam int CLRC = 2;

  logic        clk = 1'b0;
  logic        clrN;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic        prog;
  logic [7:0]  a;
  logic [11:0] d;
  logic        cpuClr;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  sap2_prog_loader #(.HOLD(HOLD), .CLR_CYCLES(CLRC)) dut (
    .clk(clk), .clr_n(clrN), .in_data(inData), .in_valid(inValid),
    .in_ready(inReady), .prog(prog), .a(a), .d(d), .cpu_clr(cpuClr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor state
  logic [7:0]  qA[$];
  logic [11:0] qD[$];
  int          qLen[$];
  int          clrCycles, doneCount, stableErr, overlapErr, readyErr;
  logic        progPrev = 1'b0;
  logic [7:0]  lastA;
  logic [11:0] lastD;
  int          curLen;

  logic [11:0] wordsBuf[256];
  logic [11:0] test1Words[12] = '{12'hFD0, 12'h409, 12'hF80, 12'h806,
                                  12'h00A, 12'h607, 12'h00B, 12'hFE0,
                                  12'hFF0, 12'h001, 12'hFFF, 12'h000};

  // Record prog windows and protocol observations away from the active edge.
  always @(negedge clk) begin
    if (prog && !progPrev) begin
      qA.push_back(a);
      qD.push_back(d);
      lastA  = a;
      lastD  = d;
      curLen = 1;
    end else if (prog) begin
      curLen++;
      if (a !== lastA || d !== lastD) stableErr++;
    end else if (progPrev) begin
      qLen.push_back(curLen);
    end
    if (cpuClr) clrCycles++;
    if (prog && cpuClr) overlapErr++;
    if ((prog || cpuClr) && inReady) readyErr++;
    if (done) doneCount++;
    progPrev = prog;
  end

  task automatic clearMon();
    qA.delete();
    qD.delete();
    qLen.delete();
    clrCycles  = 0;
    doneCount  = 0;
    stableErr  = 0;
    overlapErr = 0;
    readyErr   = 0;
  endtask

  // Present one byte and wait (bounded) for it to transfer. Returns #1 after
  // the accepting edge. keep leaves in_valid high afterwards.
  task automatic sendByte(input logic [7:0] b, input bit gap, input bit keep);
    int t;
    if (gap) begin
      inValid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    inData  = b;
    inValid = 1'b1;
    t = 0;
    while (!inReady && t < 200) begin @(posedge clk); #1; t++; end
    checks++;
    if (!inReady) begin
      errors++;
      $display("[TB] FAIL sendByte_timeout byte=%h ready=%b want 1", b, inReady);
    end else begin
      @(posedge clk); #1;
    end
    if (!keep) inValid = 1'b0;
  endtask

  task automatic sendFrame(input int n, input bit gap, input bit keep);
    logic [7:0] sum;
    logic [7:0] cnt;
    cnt = n[7:0];
    sum = cnt;
    sendByte(cnt, gap, keep);
    for (int i = 0; i < n; i++) begin
      sendByte({4'h0, wordsBuf[i][11:8]}, gap, keep);
      sendByte(wordsBuf[i][7:0], gap, keep);
      sum = sum + {4'h0, wordsBuf[i][11:8]} + wordsBuf[i][7:0];
    end
`ifdef SAP2_LOADER_CHECKSUM_EN
    sendByte(8'h00 - sum, gap, keep);
`endif
    inValid = 1'b0;
  endtask

  task automatic waitDone(input int want);
    int t;
    t = 0;
    while (doneCount < want && t < 3000) begin @(posedge clk); #1; t++; end
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (doneCount !== want) begin
      errors++;
      $display("[TB] FAIL done_count got %0d want %0d", doneCount, want);
    end
  endtask

  task automatic test_reset();
    clrN    = 1'b0;
    inValid = 1'b0;
    inData  = 8'h00;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({prog, a, d, cpuClr, busy, done, err, inReady} !== {1'b0, 8'h00, 12'h000, 5'b00001}) begin
      errors++;
      $display("[TB] FAIL reset_outputs got prog=%b a=%h d=%h clr=%b busy=%b done=%b err=%b rdy=%b want 0/00/000/0/0/0/0/1",
               prog, a, d, cpuClr, busy, done, err, inReady);
    end
    clrN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frame(input bit gap, input bit keep, input string name);
    clearMon();
    for (int i = 0; i < 12; i++) wordsBuf[i] = test1Words[i];
    sendFrame(12, gap, keep);
    waitDone(1);
    checks++;
    if (qA.size() !== 12) begin
      errors++;
      $display("[TB] FAIL %s_windows got %0d want 12", name, qA.size());
    end
    for (int i = 0; i < 12 && i < qA.size(); i++) begin
      checks++;
      if (qA[i] !== 8'(i) || qD[i] !== test1Words[i] || qLen[i] !== HOLD) begin
        errors++;
        $display("[TB] FAIL %s_word%0d got a=%h d=%h len=%0d want a=%h d=%h len=%0d",
                 name, i, qA[i], qD[i], qLen[i], 8'(i), test1Words[i], HOLD);
      end
    end
    checks++;
    if (clrCycles !== CLRC || stableErr !== 0 || overlapErr !== 0 || readyErr !== 0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_tail got clr=%0d stab=%0d ovl=%0d rdy=%0d err=%b want %0d/0/0/0/0",
               name, clrCycles, stableErr, overlapErr, readyErr, err, CLRC);
    end
  endtask

  task automatic test_full256();
    clearMon();
    for (int i = 0; i < 256; i++) wordsBuf[i] = {4'h0, 8'(i)};
    sendFrame(256, 1'b0, 1'b0);
    waitDone(1);
    checks++;
    if (qA.size() !== 256) begin
      errors++;
      $display("[TB] FAIL full256_windows got %0d want 256", qA.size());
    end
    for (int i = 0; i < 256 && i < qA.size(); i++) begin
      if (qA[i] !== 8'(i) || qD[i] !== {4'h0, 8'(i)}) begin
        checks++;
        errors++;
        $display("[TB] FAIL full256_word%0d got a=%h d=%h want a=%h d=%h",
                 i, qA[i], qD[i], 8'(i), {4'h0, 8'(i)});
      end
    end
    checks++;
    if (qA.size() == 256 && (qA[255] !== 8'hFF || qD[255] !== 12'h0FF)) begin
      errors++;
      $display("[TB] FAIL full256_last got a=%h d=%h want FF/0FF", qA[255], qD[255]);
    end
    checks++;
    if (clrCycles !== CLRC) begin
      errors++;
      $display("[TB] FAIL full256_clr got %0d want %0d", clrCycles, CLRC);
    end
  endtask

  task automatic test_reset_midframe();
    clearMon();
    for (int i = 0; i < 12; i++) wordsBuf[i] = test1Words[i];
    sendByte(8'h0C, 1'b0, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      sendByte({4'h0, wordsBuf[i][11:8]}, 1'b0, 1'b0);
      sendByte(wordsBuf[i][7:0], 1'b0, 1'b0);
    end
    checks++;
    if (prog !== 1'b1 || a !== 8'h05 || d !== 12'h607) begin
      errors++;
      $display("[TB] FAIL midframe_write got prog=%b a=%h d=%h want 1/05/607", prog, a, d);
    end
    clrN = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({prog, a, d, cpuClr, busy, done, err} !== {1'b0, 8'h00, 12'h000, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL midframe_reset got prog=%b a=%h d=%h clr=%b busy=%b done=%b err=%b want all 0",
               prog, a, d, cpuClr, busy, done, err);
    end
    clrN = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (doneCount !== 0 || clrCycles !== 0) begin
      errors++;
      $display("[TB] FAIL midframe_nodone got done=%0d clr=%0d want 0/0", doneCount, clrCycles);
    end
    test_frame(1'b0, 1'b0, "reload");
  endtask

  task automatic test_nibble_latency();
    clearMon();
    wordsBuf[0] = 12'h409;
    sendByte(8'h01, 1'b0, 1'b0);
    sendByte(8'hF4, 1'b0, 1'b0);
    sendByte(8'h09, 1'b0, 1'b0);
    checks++;
    if (prog !== 1'b1 || a !== 8'h00 || d !== 12'h409) begin
      errors++;
      $display("[TB] FAIL nibble_latency got prog=%b a=%h d=%h want 1/00/409", prog, a, d);
    end
`ifdef SAP2_LOADER_CHECKSUM_EN
    sendByte(8'h02, 1'b0, 1'b0);
`endif
    waitDone(1);
  endtask

  task automatic test_checksum();
`ifdef SAP2_LOADER_CHECKSUM_EN
    clearMon();
    sendByte(8'h01, 1'b0, 1'b0);
    sendByte(8'h04, 1'b0, 1'b0);
    sendByte(8'h09, 1'b0, 1'b0);
    sendByte(8'hF2, 1'b0, 1'b0);
    waitDone(1);
    checks++;
    if (err !== 1'b0 || clrCycles !== CLRC) begin
      errors++;
      $display("[TB] FAIL chk_pass got err=%b clr=%0d want 0/%0d", err, clrCycles, CLRC);
    end
    clearMon();
    sendByte(8'h01, 1'b0, 1'b0);
    sendByte(8'h04, 1'b0, 1'b0);
    sendByte(8'h09, 1'b0, 1'b0);
    sendByte(8'hF3, 1'b0, 1'b0);
    waitDone(1);
    checks++;
    if (err !== 1'b1 || clrCycles !== 0) begin
      errors++;
      $display("[TB] FAIL chk_fail got err=%b clr=%0d want 1/0", err, clrCycles);
    end
    clearMon();
    for (int i = 0; i < 12; i++) wordsBuf[i] = test1Words[i];
    sendFrame(12, 1'b0, 1'b0);
    waitDone(1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL chk_clear got err=%b want 0", err);
    end
`else
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_tied got err=%b want 0", err);
    end
`endif
  endtask

  initial begin
    clearMon();
    test_reset();
    test_frame(1'b0, 1'b0, "frame12");
    test_full256();
    test_frame(1'b1, 1'b1, "gaps");
    test_reset_midframe();
    test_checksum();
    test_nibble_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
